// File: rtl/match_controller.sv
// Match sequencer: IDLE -> INTRO -> PVP/PVAI fight -> GAME_OVER, with health, round timer and winner.
// Optional MATCH_PAUSE_EN adds a pause input and a paused output for the fight states.
module match_controller #(
   parameter int INTRO_FRAMES   = 120,
   parameter int FRAMES_PER_SEC = 60,
   parameter int ROUND_SECS     = 99,
   parameter int HEALTH_W       = 4,
   parameter int MAX_HEALTH     = 8,
   parameter int OVER_FRAMES    = 180
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick,
   input  logic                start,
   input  logic                mode_sel,
   input  logic                hit_p1,
   input  logic                hit_p2,
`ifdef MATCH_PAUSE_EN
   input  logic                pause,
   output logic                paused,
`endif
   output logic [2:0]          state,
   output logic                ai_en,
   output logic                players_rst,
   output logic [HEALTH_W-1:0] p1_health,
   output logic [HEALTH_W-1:0] p2_health,
   output logic [6:0]          round_secs,
   output logic [1:0]          winner
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INTRO     = 3'd1,
      ST_PVP       = 3'd2,
      ST_PVAI      = 3'd3,
      ST_GAME_OVER = 3'd4
   } state_t;

   localparam int MAX_A  = (INTRO_FRAMES > OVER_FRAMES) ? INTRO_FRAMES : OVER_FRAMES;
   localparam int MAX_FR = (MAX_A > FRAMES_PER_SEC) ? MAX_A : FRAMES_PER_SEC;
   localparam int CNT_W  = $clog2(MAX_FR + 1);

   localparam logic [HEALTH_W-1:0] HEALTH_INIT = HEALTH_W'(MAX_HEALTH);
   localparam logic [6:0]          SECS_INIT   = 7'(ROUND_SECS);

   state_t              state_q, state_d;
   logic                ai_en_q, ai_en_d;
   logic                players_rst_q, players_rst_d;
   logic [HEALTH_W-1:0] p1_health_q, p1_health_d;
   logic [HEALTH_W-1:0] p2_health_q, p2_health_d;
   logic [6:0]          round_secs_q, round_secs_d;
   logic [1:0]          winner_q, winner_d;
   logic [CNT_W-1:0]    frame_q, frame_d;
   logic                hold;
   logic                p1_ko, p2_ko;
`ifdef MATCH_PAUSE_EN
   logic                paused_q, paused_d;
`endif

   assign p1_ko = (p1_health_q == '0);
   assign p2_ko = (p2_health_q == '0);

   always_comb begin
      state_d      = state_q;
      ai_en_d      = ai_en_q;
      p1_health_d  = p1_health_q;
      p2_health_d  = p2_health_q;
      round_secs_d = round_secs_q;
      winner_d     = winner_q;
      frame_d      = frame_q;
      hold         = 1'b0;
`ifdef MATCH_PAUSE_EN
      paused_d     = paused_q;
      hold         = paused_q | pause;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_INTRO;
               ai_en_d      = mode_sel;
               p1_health_d  = HEALTH_INIT;
               p2_health_d  = HEALTH_INIT;
               round_secs_d = SECS_INIT;
               winner_d     = 2'b00;
               frame_d      = '0;
            end
         end
         ST_INTRO: begin
            if (tick) begin
               if (frame_q == CNT_W'(INTRO_FRAMES - 1)) begin
                  state_d = ai_en_q ? ST_PVAI : ST_PVP;
                  frame_d = '0;
               end else begin
                  frame_d = frame_q + 1'b1;
               end
            end
         end
         ST_PVP, ST_PVAI: begin
            // End of fight is judged on registered values; KO outranks timeout.
            if (p1_ko || p2_ko) begin
               state_d  = ST_GAME_OVER;
               frame_d  = '0;
               winner_d = {p1_ko, p2_ko};
            end else if (round_secs_q == '0) begin
               state_d  = ST_GAME_OVER;
               frame_d  = '0;
               if (p1_health_q > p2_health_q)      winner_d = 2'b01;
               else if (p2_health_q > p1_health_q) winner_d = 2'b10;
               else                                winner_d = 2'b11;
            end else if (!hold) begin
               // Both healths and the timer are nonzero here, so a single decrement cannot wrap.
               if (hit_p1) p2_health_d = p2_health_q - 1'b1;
               if (hit_p2) p1_health_d = p1_health_q - 1'b1;
               if (tick) begin
                  if (frame_q == CNT_W'(FRAMES_PER_SEC - 1)) begin
                     frame_d      = '0;
                     round_secs_d = round_secs_q - 1'b1;
                  end else begin
                     frame_d = frame_q + 1'b1;
                  end
               end
            end
`ifdef MATCH_PAUSE_EN
            if (start) paused_d = ~paused_q;
`endif
         end
         ST_GAME_OVER: begin
            if (start || (tick && frame_q == CNT_W'(OVER_FRAMES - 1))) begin
               state_d = ST_IDLE;
               frame_d = '0;
            end else if (tick) begin
               frame_d = frame_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            frame_d = '0;
         end
      endcase
`ifdef MATCH_PAUSE_EN
      if (state_d != ST_PVP && state_d != ST_PVAI) paused_d = 1'b0;
`endif
      players_rst_d = !(state_d == ST_PVP || state_d == ST_PVAI);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         ai_en_q       <= 1'b0;
         players_rst_q <= 1'b1;
         p1_health_q   <= HEALTH_INIT;
         p2_health_q   <= HEALTH_INIT;
         round_secs_q  <= SECS_INIT;
         winner_q      <= 2'b00;
         frame_q       <= '0;
`ifdef MATCH_PAUSE_EN
         paused_q      <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         ai_en_q       <= ai_en_d;
         players_rst_q <= players_rst_d;
         p1_health_q   <= p1_health_d;
         p2_health_q   <= p2_health_d;
         round_secs_q  <= round_secs_d;
         winner_q      <= winner_d;
         frame_q       <= frame_d;
`ifdef MATCH_PAUSE_EN
         paused_q      <= paused_d;
`endif
      end
   end

   assign state       = state_q;
   assign ai_en       = ai_en_q;
   assign players_rst = players_rst_q;
   assign p1_health   = p1_health_q;
   assign p2_health   = p2_health_q;
   assign round_secs  = round_secs_q;
   assign winner      = winner_q;
`ifdef MATCH_PAUSE_EN
   assign paused      = paused_q;
`endif

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with small parameters; covers MATCH_PAUSE_EN when defined.
module tb_match_controller;

   localparam int HW = 4;

   logic          clk = 1'b0;
   logic          reset, tick, start, mode_sel, hit_p1, hit_p2;
   logic [2:0]    state;
   logic          ai_en, players_rst;
   logic [HW-1:0] p1_health, p2_health;
   logic [6:0]    round_secs;
   logic [1:0]    winner;
`ifdef MATCH_PAUSE_EN
   logic          pause, paused;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   match_controller #(
      .INTRO_FRAMES(4), .FRAMES_PER_SEC(2), .ROUND_SECS(3),
      .HEALTH_W(HW), .MAX_HEALTH(3), .OVER_FRAMES(5)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick), .start(start), .mode_sel(mode_sel),
      .hit_p1(hit_p1), .hit_p2(hit_p2),
`ifdef MATCH_PAUSE_EN
      .pause(pause), .paused(paused),
`endif
      .state(state), .ai_en(ai_en), .players_rst(players_rst),
      .p1_health(p1_health), .p2_health(p2_health),
      .round_secs(round_secs), .winner(winner)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock with the given pulses held across the edge; outputs read 1ns after the edge.
   task automatic step(input logic t, input logic s, input logic m, input logic h1, input logic h2);
      tick = t; start = s; mode_sel = m; hit_p1 = h1; hit_p2 = h2;
      @(posedge clk);
      #1;
      tick = 0; start = 0; hit_p1 = 0; hit_p2 = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(0, 0, 0, 0, 0);
      reset = 1'b0;
   endtask

   task automatic enter_fight(input logic m);
      do_reset();
      step(0, 1, m, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1; tick = 0; start = 0; mode_sel = 0; hit_p1 = 0; hit_p2 = 0;
`ifdef MATCH_PAUSE_EN
      pause = 0;
`endif
      @(negedge clk);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      reset = 1'b0;
      check("rst_state", state, 0);
      check("rst_ai_en", ai_en, 0);
      check("rst_players_rst", players_rst, 1);
      check("rst_p1_health", p1_health, 3);
      check("rst_p2_health", p2_health, 3);
      check("rst_round_secs", round_secs, 3);
      check("rst_winner", winner, 0);

      // 1: PvAI entry, start ignored during INTRO
      step(0, 1, 1, 0, 0);
      check("t1_intro_state", state, 1);
      check("t1_ai_en", ai_en, 1);
      check("t1_intro_rst", players_rst, 1);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      check("t1_intro_hold", state, 1);
      check("t1_ai_en_hold", ai_en, 1);
      step(1, 0, 0, 0, 0);
      check("t1_pvai_state", state, 3);
      check("t1_pvai_rst", players_rst, 0);
      check("t1_p1_health", p1_health, 3);
      check("t1_p2_health", p2_health, 3);
      check("t1_round_secs", round_secs, 3);

      // 2: KO by player 1, extra hit ignored, start leaves GAME_OVER
      enter_fight(0);
      check("t2_pvp_state", state, 2);
      check("t2_ai_en", ai_en, 0);
      step(0, 0, 0, 1, 0);
      check("t2_p2_h2", p2_health, 2);
      step(0, 0, 0, 1, 0);
      check("t2_p2_h1", p2_health, 1);
      step(0, 0, 0, 1, 0);
      check("t2_p2_h0", p2_health, 0);
      check("t2_still_fight", state, 2);
      step(0, 0, 0, 1, 1);
      check("t2_over_state", state, 4);
      check("t2_p2_sat", p2_health, 0);
      check("t2_p1_frozen", p1_health, 3);
      check("t2_winner", winner, 1);
      check("t2_over_rst", players_rst, 1);
      step(0, 1, 0, 0, 0);
      check("t2_start_exit", state, 0);
      check("t2_winner_kept", winner, 1);

      // 3: double KO -> draw
      enter_fight(0);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      check("t3_p1_h1", p1_health, 1);
      check("t3_p2_h1", p2_health, 1);
      step(0, 0, 0, 1, 1);
      check("t3_p1_h0", p1_health, 0);
      check("t3_p2_h0", p2_health, 0);
      step(0, 0, 0, 0, 0);
      check("t3_over_state", state, 4);
      check("t3_winner", winner, 3);

      // 4: timeout, P2 ahead; auto-return to IDLE; inputs ignored in IDLE
      enter_fight(0);
      step(0, 0, 0, 0, 1);
      check("t4_p1_h2", p1_health, 2);
      step(1, 0, 0, 0, 0);
      check("t4_secs_3a", round_secs, 3);
      step(1, 0, 0, 0, 0);
      check("t4_secs_2", round_secs, 2);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("t4_secs_1", round_secs, 1);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("t4_secs_0", round_secs, 0);
      check("t4_still_fight", state, 2);
      step(0, 0, 0, 0, 0);
      check("t4_over_state", state, 4);
      check("t4_winner", winner, 2);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
      check("t4_over_hold", state, 4);
      step(1, 0, 0, 0, 0);
      check("t4_idle_state", state, 0);
      check("t4_idle_winner", winner, 2);
      check("t4_idle_rst", players_rst, 1);
      step(1, 0, 0, 1, 1);
      check("t4_idle_ignore_st", state, 0);
      check("t4_idle_ignore_p1", p1_health, 2);
      check("t4_idle_ignore_p2", p2_health, 3);
      step(0, 1, 0, 0, 0);
      check("t4_restart_state", state, 1);
      check("t4_restart_winner", winner, 0);
      check("t4_restart_p1", p1_health, 3);

      // 5: reset mid-fight
      enter_fight(0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 1);
      check("t5_p1_h1", p1_health, 1);
      check("t5_p2_h2", p2_health, 2);
      reset = 1'b1;
      step(1, 0, 0, 0, 0);
      reset = 1'b0;
      check("t5_state", state, 0);
      check("t5_p1", p1_health, 3);
      check("t5_p2", p2_health, 3);
      check("t5_secs", round_secs, 3);
      check("t5_rst", players_rst, 1);

`ifdef MATCH_PAUSE_EN
      // 6: pause toggle and level pause
      enter_fight(0);
      check("t6_paused0", paused, 0);
      step(0, 1, 0, 0, 0);
      check("t6_paused1", paused, 1);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      check("t6_secs_frozen", round_secs, 3);
      check("t6_p2_frozen", p2_health, 3);
      check("t6_rst_low", players_rst, 0);
      check("t6_state", state, 2);
      step(0, 1, 0, 0, 0);
      check("t6_unpaused", paused, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("t6_secs_resume", round_secs, 2);
      pause = 1'b1;
      step(0, 0, 0, 1, 0);
      pause = 1'b0;
      check("t6_level_pause", p2_health, 3);
      step(0, 0, 0, 1, 0);
      check("t6_hit_resume", p2_health, 2);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
Top-level match sequencer for the two-player fighting game. Replaces switch-driven debug state selection with a real FSM: idle, intro countdown, a PvP or PvAI fight, and game over. Tracks both players' health and the round timer, and decides the winner. Drives the player reset line and selects the AI input source for player 2; advances on a per-frame tick enable.

Parameters:
INTRO_FRAMES, 120, number of tick pulses spent in INTRO before the fight starts
FRAMES_PER_SEC, 60, tick pulses per round-timer second
ROUND_SECS, 99, round timer start value in seconds (max 127)
HEALTH_W, 4, health counter width
MAX_HEALTH, 8, starting health per player (must be <= 2^HEALTH_W-1)
OVER_FRAMES, 180, tick pulses spent in GAME_OVER before auto-return to IDLE

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous active-high reset
tick  input  1  one-cycle frame strobe; all frame counting uses it
start  input  1  one-cycle start/confirm pulse
mode_sel  input  1  0 = PvP, 1 = PvAI; sampled on start in IDLE
hit_p1  input  1  one-cycle pulse: player 1 landed a hit on player 2
hit_p2  input  1  one-cycle pulse: player 2 landed a hit on player 1
state  output  3  current state encoding
ai_en  output  1  high = player 2 driven by random source
players_rst  output  1  hold players in reset
p1_health  output  HEALTH_W  player 1 health
p2_health  output  HEALTH_W  player 2 health
round_secs  output  7  remaining round seconds
winner  output  2  00 none, 01 P1, 10 P2, 11 draw

Behaviour:
- Clock is clk. Reset is synchronous and active-high. All outputs are registered.
- State encoding:
  - IDLE=0, INTRO=1, PVP=2, PVAI=3, GAME_OVER=4.
  - Codes 5–7 are illegal and go to IDLE on the next edge.
- Reset values:
  - state=IDLE, ai_en=0, players_rst=1.
  - p1_health=p2_health=MAX_HEALTH, round_secs=ROUND_SECS, winner=00.
  - All internal frame counters are cleared.
- players_rst=1 in IDLE, INTRO and GAME_OVER; 0 only in PVP/PVAI. It is registered, so it follows the state with no extra lag.
- ai_en is the latched mode bit. It updates only on the IDLE->INTRO transition.
- IDLE:
  - On start, go to INTRO and latch mode_sel.
  - On that same edge: both healths <= MAX_HEALTH, round_secs <= ROUND_SECS, winner <= 00, frame counter <= 0.
  - tick and hits are ignored.
- INTRO:
  - Counts tick pulses.
  - On the INTRO_FRAMES-th tick, go to PVP (ai_en=0) or PVAI (ai_en=1).
  - start is ignored.
- PVP/PVAI fight rules:
  - hit_p1 decrements p2_health; hit_p2 decrements p1_health.
  - Both decrements saturate at 0.
  - Simultaneous hits both apply on the same edge.
  - Hits are ignored in any cycle where either registered health is already 0 (frozen).
- PVP/PVAI timer:
  - Every FRAMES_PER_SEC ticks, round_secs decrements.
  - It saturates at 0 and the frame counter wraps to 0.
- Fight end (evaluated on registered values, so GAME_OVER is entered one edge after the terminating update):
  - Either health == 0, or round_secs == 0: go to GAME_OVER.
  - Winner with a zero health: P1 if only p2_health==0; P2 if only p1_health==0; draw if both are 0.
  - Winner on timeout with both nonzero: the higher health wins; equal health is a draw.
  - Health KO takes priority over timeout in the same cycle.
- GAME_OVER:
  - Healths, round_secs and winner are held.
  - Counts ticks. On the OVER_FRAMES-th tick or on start (whichever comes first), go to IDLE.
  - winner is kept through IDLE until the next start.
- hit and tick inputs outside their consuming states have no effect.
- reset mid-fight: returns to the reset values on the next edge regardless of state.

Optional Feature:
Macro MATCH_PAUSE_EN.
- Defined:
  - Adds input pause (1 bit) and output paused (1 bit, reset 0).
  - In PVP/PVAI, start toggles paused.
  - While paused=1, ticks and hits are ignored and players_rst stays 0.
  - paused is cleared on any exit from the fight states and on reset.
  - The pause input is OR-ed with the toggle, giving a level-held pause.
- Undefined: no pause/paused ports, and start is ignored in fight states.

Test Plan:
All tests use INTRO_FRAMES=4, FRAMES_PER_SEC=2, ROUND_SECS=3, MAX_HEALTH=3, OVER_FRAMES=5.
1. reset, then start with mode_sel=1, then 4 ticks -> state 0->1->3; ai_en=1; players_rst drops on the edge entering PVAI; healths=3, round_secs=3.
2. In PVP: 3 hit_p1 pulses -> p2_health 3,2,1,0; GAME_OVER one edge later; winner=01; a 4th hit_p1 before the transition leaves p2_health=0 and p1_health unchanged.
3. In PVP with both healths at 1: hit_p1 and hit_p2 on the same cycle -> both 0; GAME_OVER; winner=11.
4. In PVP: one hit_p2 (p1_health=2), then 6 ticks -> round_secs 3->0; GAME_OVER; winner=10. Then 5 ticks -> IDLE with winner still 10; then start -> winner=00.
5. reset asserted during PVP with healths 1/2 -> next edge state=0, healths=3/3, round_secs=3, players_rst=1.
6. MATCH_PAUSE_EN: in PVP, start -> paused=1; 4 ticks and a hit_p1 change nothing; start -> paused=0 and ticks resume.
